// File: rtl/rv32_alu_pkg.sv
// Shared RV32 ALU definitions: selection codes, EX-unit FSM states and shift helpers.
// The ALU control block uses the same code constants, so keep them in step with it.
package rv32_alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    // 4-bit selection codes driven by ALU control
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_LUI  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_SLT  = 4'b1100;
    localparam logic [3:0] ALU_SLTU = 4'b1101;

    // EX-unit control states: IDLE accepts work, SHIFT runs the serial shifter
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    // Direction/fill flavour of a serial shift
    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_e;

    // True for the three shift selection codes
    function automatic logic isShiftSel(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

    // Maps a shift selection code onto the shifter's flavour
    function automatic shift_kind_e shiftKindOf(input logic [3:0] sel);
        shift_kind_e kind;
        case (sel)
            ALU_SLL: kind = SH_SLL;
            ALU_SRL: kind = SH_SRL;
            default: kind = SH_SRA;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial barrel-shifter replacement: moves the operand one bit per step and counts
// the remaining shift amount down. o_data is the value after the step in progress,
// so the owner can capture the final result on the same edge as the last step.
module alu_serial_shifter
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_load,
    input  logic                          i_step,
    input  logic                          i_clear,
    input  rv32_alu_pkg::shift_kind_e     i_kind,
    input  logic [rv32_alu_pkg::XLEN-1:0] i_data,
    input  logic [rv32_alu_pkg::SHAMT_W-1:0] i_shamt,
    output logic                          o_done,
    output logic [rv32_alu_pkg::XLEN-1:0] o_data
);
    import rv32_alu_pkg::*;

    shift_kind_e         r_kind;
    logic [XLEN-1:0]     r_data;
    logic [SHAMT_W-1:0]  r_count;
    logic [XLEN-1:0]     w_stepData;

    // One-bit shift of the held operand; SRA replicates the sign bit, others fill zero
    always_comb begin
        w_stepData = r_data;
        case (r_kind)
            SH_SLL:  w_stepData = {r_data[XLEN-2:0], 1'b0};
            SH_SRL:  w_stepData = {1'b0, r_data[XLEN-1:1]};
            SH_SRA:  w_stepData = {r_data[XLEN-1], r_data[XLEN-1:1]};
            default: w_stepData = r_data;
        endcase
    end

    // Operand/count registers: clear aborts, load starts, each step consumes one bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kind  <= SH_SLL;
            r_data  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_data  <= '0;
            r_count <= '0;
        end else if (i_load) begin
            r_kind  <= i_kind;
            r_data  <= i_data;
            r_count <= i_shamt;
        end else if (i_step && (r_count != '0)) begin
            r_data  <= w_stepData;
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == SHAMT_W'(1));
    assign o_data = w_stepData;

endmodule

// File: rtl/ex_alu_unit.sv
// RV32 execute-stage ALU with valid/ready handshakes. Logic and arithmetic ops
// complete at the accept edge; shifts by a non-zero amount run serially, one bit
// per cycle, and block new work until their result is written.
module ex_alu_unit
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_sel,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        lt,
    output logic        ltu,
    output logic        busy
);
    import rv32_alu_pkg::*;

    alu_state_e   r_state;
    alu_state_e   w_nextState;

    logic [31:0]  r_result;
    logic         r_zero;
    logic         r_lt;
    logic         r_ltu;
    logic         r_outValid;
    logic         r_pendLt;
    logic         r_pendLtu;

    logic         w_inReady;
    logic         w_accept;
    logic         w_isShift;
    logic         w_startShift;
    logic         w_writeNow;
    logic         w_shiftDone;
    logic         w_shDone;
    logic         w_lt;
    logic         w_ltu;
    logic [4:0]   w_shamt;
    logic [31:0]  w_aluResult;
    logic [31:0]  w_shData;

    assign w_lt         = $signed(op_a) < $signed(op_b);
    assign w_ltu        = op_a < op_b;
    assign w_shamt      = op_b[4:0];
    assign w_isShift    = isShiftSel(alu_sel);
    assign w_accept     = in_valid && w_inReady;
    assign w_startShift = w_accept && w_isShift && (w_shamt != 5'd0);
    assign w_writeNow   = w_accept && !w_startShift;
    assign w_shiftDone  = (r_state == ST_SHIFT) && w_shDone && !flush;

    // Single-cycle result; shifts by zero fall through as a copy of op_a
    always_comb begin
        w_aluResult = '0;
        case (alu_sel)
            ALU_AND:  w_aluResult = op_a & op_b;
            ALU_OR:   w_aluResult = op_a | op_b;
            ALU_ADD:  w_aluResult = op_a + op_b;
            ALU_SUB:  w_aluResult = op_a - op_b;
            ALU_XOR:  w_aluResult = op_a ^ op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  w_aluResult = op_a;
            ALU_SLT:  w_aluResult = {31'd0, w_lt};
            ALU_SLTU: w_aluResult = {31'd0, w_ltu};
            ALU_LUI:  w_aluResult = op_b;
            default:  w_aluResult = '0;
        endcase
    end

    alu_serial_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_startShift),
        .i_step  (r_state == ST_SHIFT),
        .i_clear (flush),
        .i_kind  (shiftKindOf(alu_sel)),
        .i_data  (op_a),
        .i_shamt (w_shamt),
        .o_done  (w_shDone),
        .o_data  (w_shData)
    );

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and input handshake; flush blocks acceptance and aborts a shift
    always_comb begin
        w_nextState = r_state;
        w_inReady   = (r_state == ST_IDLE) && (!r_outValid || out_ready) && !flush;
        case (r_state)
            ST_IDLE: begin
                if (w_startShift) begin
                    w_nextState = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (flush || w_shDone) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Comparison flags of a shift are taken at accept and held until its result lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pendLt  <= 1'b0;
            r_pendLtu <= 1'b0;
        end else if (w_startShift) begin
            r_pendLt  <= w_lt;
            r_pendLtu <= w_ltu;
        end
    end

    // Output register: flush wins, then a fresh result, then consumer drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_lt       <= 1'b0;
            r_ltu      <= 1'b0;
            r_outValid <= 1'b0;
        end else if (flush) begin
            r_outValid <= 1'b0;
        end else if (w_writeNow) begin
            r_result   <= w_aluResult;
            r_zero     <= (w_aluResult == '0);
            r_lt       <= w_lt;
            r_ltu      <= w_ltu;
            r_outValid <= 1'b1;
        end else if (w_shiftDone) begin
            r_result   <= w_shData;
            r_zero     <= (w_shData == '0);
            r_lt       <= r_pendLt;
            r_ltu      <= r_pendLtu;
            r_outValid <= 1'b1;
        end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign in_ready  = w_inReady;
    assign out_valid = r_outValid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign lt        = r_lt;
    assign ltu       = r_ltu;
    assign busy      = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed corner cases followed by random
// operations compared against an arithmetic reference model.
module tb_ex_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_alu_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_sel   (alu_sel),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .lt        (lt),
        .ltu       (ltu),
        .busy      (busy)
    );

    // Reference result straight from the ISA meaning of each selection code
    function automatic logic [31:0] refResult(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (sel)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0011: return a ^ b;
            4'b1001: return a << sh;
            4'b1010: return a >> sh;
            4'b1011: return $unsigned($signed(a) >>> sh);
            4'b1100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1101: return (a < b) ? 32'd1 : 32'd0;
            4'b1000: return b;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from accept to visible result: shifts by n>0 take n+1, all else 1
    function automatic int refLatency(input logic [3:0] sel, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        if ((sel == 4'b1001 || sel == 4'b1010 || sel == 4'b1011) && sh != 0) return sh + 1;
        return 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Offers one operation at a falling edge, waits for its result and checks it all
    task automatic applyStimulus(input string tag, input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        int busyCnt;
        logic sawReady;
        logic [31:0] expRes;
        expRes = refResult(sel, a, b);
        @(negedge clk);
        checkOutput({tag, ".in_ready_offer"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_sel  = sel;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        cycles   = 1;
        busyCnt  = 0;
        sawReady = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (busy) busyCnt++;
            if (in_ready) sawReady = 1'b1;
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(refLatency(sel, b)));
        checkOutput({tag, ".busy_cycles"}, 32'(busyCnt), 32'(refLatency(sel, b) - 1));
        checkOutput({tag, ".ready_while_busy"}, 32'(sawReady), 32'd0);
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".busy_end"}, 32'(busy), 32'd0);
        checkOutput({tag, ".result"}, result, expRes);
        checkOutput({tag, ".zero"}, 32'(zero), 32'(expRes == 32'd0));
        checkOutput({tag, ".lt"}, 32'(lt), 32'($signed(a) < $signed(b)));
        checkOutput({tag, ".ltu"}, 32'(ltu), 32'(a < b));
    endtask

    // Consumer takes the held result for one edge
    task automatic drainResult(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic sawValid;
        logic [3:0] rSel;
        logic [31:0] rA;
        logic [31:0] rB;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_sel   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("reset.result", result, 32'd0);
        checkOutput("reset.zero", 32'(zero), 32'd1);
        checkOutput("reset.lt", 32'(lt), 32'd0);
        checkOutput("reset.ltu", 32'(ltu), 32'd0);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        applyStimulus("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'd1);
        drainResult("add_ovf");
        applyStimulus("sub_eq", 4'b0110, 32'd5, 32'd5);
        drainResult("sub_eq");
        applyStimulus("slt_neg", 4'b1100, 32'hFFFF_FFFF, 32'd1);
        drainResult("slt_neg");
        applyStimulus("sra31", 4'b1011, 32'h8000_0000, 32'd31);
        drainResult("sra31");
        applyStimulus("sel1111", 4'b1111, 32'd3, 32'd4);
        drainResult("sel1111");
        applyStimulus("lui", 4'b1000, 32'hDEAD_BEEF, 32'h1234_5000);
        drainResult("lui");
        applyStimulus("sll_sh0", 4'b1001, 32'hA5A5_0001, 32'hFFFF_FFE0);
        drainResult("sll_sh0");
        applyStimulus("srl_hi_ignored", 4'b1010, 32'hF000_000F, 32'hFFFF_FFE4);
        drainResult("srl_hi_ignored");

        // Backpressure: result held while a new XOR waits, then accepted on the release edge
        $display("[TB] backpressure and back-to-back");
        applyStimulus("bp_add", 4'b0010, 32'd10, 32'd20);
        in_valid = 1'b1;
        alu_sel  = 4'b0011;
        op_a     = 32'hF0F0_1234;
        op_b     = 32'h0FF0_4321;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp.in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
            checkOutput("bp.result_stable", result, 32'd30);
            checkOutput("bp.valid_stable", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp.in_ready_release", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b.out_valid", 32'(out_valid), 32'd1);
        checkOutput("b2b.result", result, refResult(4'b0011, 32'hF0F0_1234, 32'h0FF0_4321));
        drainResult("b2b");

        // Flush four cycles into a ten-bit SLL
        $display("[TB] flush mid-shift");
        in_valid = 1'b1;
        alu_sel  = 4'b1001;
        op_a     = 32'd1;
        op_b     = 32'd10;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("flush.busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("flush.in_ready_during", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flush.busy_after", 32'(busy), 32'd0);
        checkOutput("flush.in_ready_after", 32'(in_ready), 32'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("flush.no_result", 32'(sawValid), 32'd0);

        // Flush beats an offered op and drops a held result
        applyStimulus("fl_hold", 4'b0001, 32'h0000_00F0, 32'h0000_000F);
        flush    = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        alu_sel  = 4'b0010;
        op_a     = 32'd7;
        op_b     = 32'd8;
        #1;
        checkOutput("flush.blocks_accept", 32'(in_ready), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("flush.clears_valid", 32'(out_valid), 32'd0);
        checkOutput("flush.result_kept", result, 32'h0000_00FF);
        @(negedge clk);
        checkOutput("flush.input_dropped", 32'(out_valid), 32'd0);

        // Reset asserted in the middle of a shift
        $display("[TB] reset mid-shift");
        applyStimulus("pre_rst", 4'b0010, 32'd1, 32'd2);
        drainResult("pre_rst");
        in_valid = 1'b1;
        alu_sel  = 4'b1010;
        op_a     = 32'hFFFF_0000;
        op_b     = 32'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.result", result, 32'd0);
        checkOutput("rst_mid.zero", 32'(zero), 32'd1);
        checkOutput("rst_mid.lt", 32'(lt), 32'd0);
        checkOutput("rst_mid.ltu", 32'(ltu), 32'd0);
        checkOutput("rst_mid.busy", 32'(busy), 32'd0);
        checkOutput("rst_mid.out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rst_mid.in_ready", 32'(in_ready), 32'd1);
        sawValid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid || busy) sawValid = 1'b1;
        end
        checkOutput("rst_mid.discarded", 32'(sawValid), 32'd0);

        // Random operations against the reference model
        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            rSel = 4'($urandom_range(0, 15));
            rA   = $urandom;
            rB   = $urandom;
            applyStimulus($sformatf("rnd%0d", i), rSel, rA, rB);
            drainResult($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above stalls
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

endmodule
